text_ring_buffer: RTL and testbench



---
 rtl/text_ring_buffer.sv | 178 +++++++++++++++++
 tb/tb_text_ring_buffer.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/text_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module   : text_ring_buffer
// Desc     : ROWS x COLS dual-port text cell store, ring-mapped rows, fill/scroll engine
// Revision : 1.0
// ============================================================================
module text_ring_buffer #(
    parameter int                DATA_W    = 16,
    parameter int                COLS      = 80,
    parameter int                ROWS      = 32,
    parameter logic [DATA_W-1:0] FILL_INIT = 16'h0720,
    parameter int                CW        = $clog2(COLS),
    parameter int                RW        = $clog2(ROWS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [RW-1:0]     cpu_row,
    input  logic [CW-1:0]     cpu_col,
    input  logic              cpu_we,
    input  logic              cpu_re,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_rvalid,
    input  logic [RW-1:0]     rd_row,
    input  logic [CW-1:0]     rd_col,
    output logic [DATA_W-1:0] rd_data,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [RW-1:0]     cmd_row,
    input  logic [DATA_W-1:0] cmd_fill,
    output logic              busy,
    output logic [RW-1:0]     top_row
);

    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [1:0] OP_CLEAR_SCREEN = 2'b00;
    localparam logic [1:0] OP_SCROLL_UP    = 2'b01;
    localparam logic [1:0] OP_CLEAR_ROW    = 2'b10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    // Power-up content only; reset never touches the cell array.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: FILL_INIT};

    state_t            state_q, state_d;
    logic [RW-1:0]     top_row_q, top_row_d;
    logic [AW-1:0]     fill_addr_q, fill_addr_d;
    logic [AW-1:0]     fill_last_q, fill_last_d;
    logic [DATA_W-1:0] fill_data_q, fill_data_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic              cpu_rvalid_q, cpu_rvalid_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;

    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;
    logic [AW-1:0]     cpu_addr, rd_addr, row_addr;
    logic              cpu_ok, rd_ok;

    function automatic logic [AW-1:0] row_base(input logic [RW-1:0] row, input logic [RW-1:0] top);
        logic [RW:0] phys;
        phys = {1'b0, row} + {1'b0, top};
        if (phys >= (RW+1)'(ROWS))
            phys = phys - (RW+1)'(ROWS);
        return AW'(phys) * AW'(COLS);
    endfunction

    function automatic logic in_range(input logic [RW-1:0] row, input logic [CW-1:0] col);
        return (int'(row) < ROWS) && (int'(col) < COLS);
    endfunction

    assign cpu_addr = row_base(cpu_row, top_row_q) + AW'(cpu_col);
    assign rd_addr  = row_base(rd_row, top_row_q) + AW'(rd_col);
    assign row_addr = row_base(cmd_row, top_row_q);
    assign cpu_ok   = in_range(cpu_row, cpu_col);
    assign rd_ok    = in_range(rd_row, rd_col);

    assign cmd_ready  = (state_q == IDLE) && reset_n;
    assign busy       = (state_q == FILL);
    assign top_row    = top_row_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;
    assign rd_data    = rd_data_q;

    always_comb begin
        state_d      = state_q;
        top_row_d    = top_row_q;
        fill_addr_d  = fill_addr_q;
        fill_last_d  = fill_last_q;
        fill_data_d  = fill_data_q;
        cpu_rdata_d  = cpu_rdata_q;
        cpu_rvalid_d = 1'b0;
        mem_we       = 1'b0;
        mem_waddr    = cpu_addr;
        mem_wdata    = cpu_wdata;
        rd_data_d    = rd_ok ? mem_q[rd_addr] : '0;

        if (state_q == FILL) begin
            mem_we    = 1'b1;
            mem_waddr = fill_addr_q;
            mem_wdata = fill_data_q;
            if (fill_addr_q == fill_last_q)
                state_d = IDLE;
            else
                fill_addr_d = fill_addr_q + AW'(1);
        end else begin
            mem_we = cpu_we && cpu_ok;
            if (cpu_re) begin
                cpu_rvalid_d = 1'b1;
                cpu_rdata_d  = cpu_ok ? mem_q[cpu_addr] : '0;
            end
            if (cmd_valid && cmd_ready) begin
                fill_data_d = cmd_fill;
                case (cmd_op)
                    OP_CLEAR_SCREEN: begin
                        top_row_d   = '0;
                        fill_addr_d = '0;
                        fill_last_d = AW'(DEPTH - 1);
                        state_d     = FILL;
                    end
                    OP_SCROLL_UP: begin
                        // Old top row becomes the new bottom line and is blanked.
                        top_row_d   = (top_row_q == RW'(ROWS - 1)) ? '0 : top_row_q + RW'(1);
                        fill_addr_d = row_base(top_row_q, '0);
                        fill_last_d = row_base(top_row_q, '0) + AW'(COLS - 1);
                        state_d     = FILL;
                    end
                    OP_CLEAR_ROW: begin
                        if (int'(cmd_row) < ROWS) begin
                            fill_addr_d = row_addr;
                            fill_last_d = row_addr + AW'(COLS - 1);
                            state_d     = FILL;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (!reset_n)
            mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem_q[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            top_row_q    <= '0;
            fill_addr_q  <= '0;
            fill_last_q  <= '0;
            fill_data_q  <= '0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            top_row_q    <= top_row_d;
            fill_addr_q  <= fill_addr_d;
            fill_last_q  <= fill_last_d;
            fill_data_q  <= fill_data_d;
            cpu_rdata_q  <= cpu_rdata_d;
            cpu_rvalid_q <= cpu_rvalid_d;
            rd_data_q    <= rd_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_text_ring_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_text_ring_buffer
// Desc     : Self-checking bench for text_ring_buffer against a row/column model
// Revision : 1.0
// ============================================================================
module tb_text_ring_buffer;

    localparam int          DATA_W    = 16;
    localparam int          COLS      = 80;
    localparam int          ROWS      = 32;
    localparam int          CW        = $clog2(COLS);
    localparam int          RW        = $clog2(ROWS);
    localparam logic [15:0] FILL_INIT = 16'h0720;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [RW-1:0]     cpu_row = '0;
    logic [CW-1:0]     cpu_col = '0;
    logic              cpu_we = 1'b0;
    logic              cpu_re = 1'b0;
    logic [DATA_W-1:0] cpu_wdata = '0;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;
    logic [RW-1:0]     rd_row = '0;
    logic [CW-1:0]     rd_col = '0;
    logic [DATA_W-1:0] rd_data;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [1:0]        cmd_op = '0;
    logic [RW-1:0]     cmd_row = '0;
    logic [DATA_W-1:0] cmd_fill = '0;
    logic              busy;
    logic [RW-1:0]     top_row;

    always #5 clk = ~clk;

    text_ring_buffer #(
        .DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .FILL_INIT(FILL_INIT)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_row(cpu_row), .cpu_col(cpu_col), .cpu_we(cpu_we), .cpu_re(cpu_re),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_row(cmd_row), .cmd_fill(cmd_fill), .busy(busy), .top_row(top_row)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: screen content indexed by physical row, plus the current top row.
    logic [15:0] model [ROWS][COLS];
    int          m_top = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input int row, input int col);
        if (row >= ROWS || col >= COLS)
            return 16'h0000;
        return model[(row + m_top) % ROWS][col];
    endfunction

    function automatic void model_write(input int row, input int col, input logic [15:0] d);
        if (row < ROWS && col < COLS)
            model[(row + m_top) % ROWS][col] = d;
    endfunction

    function automatic void model_cmd(input logic [1:0] op, input int row, input logic [15:0] fill);
        int ph;
        case (op)
            2'b00: begin
                m_top = 0;
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++) model[r][c] = fill;
            end
            2'b01: begin
                ph    = m_top;
                m_top = (m_top + 1) % ROWS;
                for (int c = 0; c < COLS; c++) model[ph][c] = fill;
            end
            2'b10: begin
                if (row < ROWS)
                    for (int c = 0; c < COLS; c++) model[(row + m_top) % ROWS][c] = fill;
            end
            default: ;
        endcase
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_write(input int row, input int col, input logic [15:0] d);
        cpu_row = RW'(row); cpu_col = CW'(col); cpu_wdata = d; cpu_we = 1'b1;
        step;
        cpu_we = 1'b0;
        model_write(row, col, d);
    endtask

    task automatic cpu_read(input string tag, input int row, input int col);
        logic [15:0] exp;
        cpu_row = RW'(row); cpu_col = CW'(col); cpu_re = 1'b1;
        exp = model_read(row, col);
        step;
        cpu_re = 1'b0;
        check({tag, "_rvalid"}, cpu_rvalid, 1);
        check({tag, "_rdata"}, cpu_rdata, exp);
    endtask

    task automatic rd_check(input string tag, input int row, input int col);
        logic [15:0] exp;
        rd_row = RW'(row); rd_col = CW'(col);
        exp = model_read(row, col);
        step;
        check(tag, rd_data, exp);
    endtask

    task automatic scan_row(input string tag, input int row);
        for (int c = 0; c < COLS; c++)
            rd_check(tag, row, c);
    endtask

    // Counts busy cycles after acceptance; optionally hammers port A meanwhile.
    task automatic wait_fill(input string tag, input int exp_len, input bit poke);
        int cyc = 0;
        bit ready_bad = 1'b0;
        while (busy === 1'b1 && cyc < 4000) begin
            if (cmd_ready !== 1'b0) ready_bad = 1'b1;
            cpu_we = poke; cpu_re = poke;
            cpu_row = RW'(3); cpu_col = CW'(5); cpu_wdata = 16'hFFFF;
            cyc++;
            step;
        end
        cpu_we = 1'b0; cpu_re = 1'b0;
        check({tag, "_busy_len"}, cyc, exp_len);
        check({tag, "_ready_low"}, ready_bad, 0);
        if (poke) check({tag, "_rvalid_drop"}, cpu_rvalid, 0);
    endtask

    task automatic issue_cmd(input string tag, input logic [1:0] op, input int row,
                             input logic [15:0] fill, input int exp_len, input bit poke);
        check({tag, "_ready"}, cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_row = RW'(row); cmd_fill = fill;
        step;
        cmd_valid = 1'b0;
        model_cmd(op, row, fill);
        check({tag, "_top"}, top_row, m_top);
        wait_fill(tag, exp_len, poke);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_rd, exp_cpu, wd;
        int rr, rc, cr, cc, row;
        bit we, re, cmd;
        logic [1:0] op;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) model[r][c] = FILL_INIT;

        // Reset values
        step; step; step;
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_cpu_rvalid", cpu_rvalid, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_busy", busy, 0);
        check("rst_top_row", top_row, 0);
        reset_n = 1'b1;
        step;
        check("rst_cmd_ready", cmd_ready, 1);

        // Power-up contents and read strobes
        rd_check("pwr_rd_0_0", 0, 0);
        rd_check("pwr_rd_31_79", 31, 79);
        cpu_read("pwr_cpu_0_0", 0, 0);
        step;
        check("rvalid_single_pulse", cpu_rvalid, 0);

        // Write, readback on both ports, simultaneous write+read
        cpu_write(5, 10, 16'h1E41);
        cpu_read("wr_cpu_5_10", 5, 10);
        rd_check("wr_rd_5_10", 5, 10);
        cpu_row = RW'(5); cpu_col = CW'(10); cpu_wdata = 16'h1111;
        cpu_we = 1'b1; cpu_re = 1'b1;
        step;
        cpu_we = 1'b0; cpu_re = 1'b0;
        check("we_re_old", cpu_rdata, 16'h1E41);
        model_write(5, 10, 16'h1111);
        cpu_read("we_re_new", 5, 10);

        // Renderer sees old contents on a same-cycle write
        rd_row = RW'(6); rd_col = CW'(6);
        exp_rd = model_read(6, 6);
        cpu_row = RW'(6); cpu_col = CW'(6); cpu_wdata = 16'hABCD; cpu_we = 1'b1;
        step;
        cpu_we = 1'b0;
        model_write(6, 6, 16'hABCD);
        check("rd_same_cycle_old", rd_data, exp_rd);
        rd_check("rd_after_write", 6, 6);

        // Out-of-range cpu column
        cpu_write(0, 100, 16'hDEAD);
        cpu_read("oor_cpu", 0, 100);
        rd_check("oor_rd", 2, 120);

        // Clear row 3 with port A poked during the fill
        for (int c = 0; c < COLS; c += 13) begin
            cpu_write(2, c, 16'h2200 + 16'(c));
            cpu_write(3, c, 16'h3300 + 16'(c));
            cpu_write(4, c, 16'h4400 + 16'(c));
        end
        issue_cmd("clr_row3", 2'b10, 3, 16'h0000, COLS, 1'b1);
        scan_row("clr_row3_r2", 2);
        scan_row("clr_row3_r3", 3);
        scan_row("clr_row3_r4", 4);

        // Scroll x33 with a marker per row
        for (int r = 0; r < ROWS; r++)
            cpu_write(r, r, 16'h8000 + 16'(r));
        for (int i = 0; i < 33; i++) begin
            issue_cmd("scroll", 2'b01, 0, 16'h0100 + 16'(i), COLS, 1'b0);
            check("scroll_top_seq", top_row, (i + 1) % ROWS);
            rd_check("scroll_bottom_c0", 31, 0);
            rd_check("scroll_bottom_c79", 31, 79);
            rd_check("scroll_row0_diag", 0, (i + 1) % ROWS);
        end
        for (int i = 0; i < 6; i++)
            issue_cmd("scroll_to7", 2'b01, 0, 16'h0200, COLS, 1'b0);
        check("top_is_7", top_row, 7);

        // Clear screen from top_row 7
        issue_cmd("clr_screen", 2'b00, 0, 16'h2B2B, ROWS * COLS, 1'b0);
        rd_check("clr_screen_0_0", 0, 0);
        rd_check("clr_screen_31_79", 31, 79);
        for (int i = 0; i < 12; i++)
            rd_check("clr_screen_rand", $urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));

        // Reset in fill cycle 40 of a clear row
        issue_cmd("pre_rst_scroll", 2'b01, 0, 16'h0300, COLS, 1'b0);
        row = (3 + m_top) % ROWS;
        cmd_valid = 1'b1; cmd_op = 2'b10; cmd_row = RW'(3); cmd_fill = 16'h5A5A;
        step;
        cmd_valid = 1'b0;
        repeat (39) step;
        reset_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_top", top_row, 0);
        m_top = 0;
        for (int c = 0; c < 39; c++) model[row][c] = 16'h5A5A;
        step; step;
        reset_n = 1'b1;
        step;
        check("midrst_ready", cmd_ready, 1);
        scan_row("midrst_row", row);

        // Reserved opcode is a no-op
        issue_cmd("op11", 2'b11, 0, 16'hEEEE, 0, 1'b0);
        check("op11_busy", busy, 0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            rr  = $urandom_range(0, ROWS - 1);
            rc  = $urandom_range(0, COLS + 15);
            cr  = $urandom_range(0, ROWS - 1);
            cc  = $urandom_range(0, COLS + 15);
            we  = ($urandom_range(0, 2) == 0);
            re  = ($urandom_range(0, 2) == 0);
            cmd = ($urandom_range(0, 24) == 0);
            op  = 2'($urandom_range(1, 3));
            wd  = 16'($urandom);
            rd_row = RW'(rr); rd_col = CW'(rc);
            cpu_row = RW'(cr); cpu_col = CW'(cc); cpu_wdata = wd;
            cpu_we = we; cpu_re = re;
            cmd_valid = cmd; cmd_op = op; cmd_row = RW'(rr); cmd_fill = 16'($urandom);
            exp_rd  = model_read(rr, rc);
            exp_cpu = model_read(cr, cc);
            step;
            cpu_we = 1'b0; cpu_re = 1'b0; cmd_valid = 1'b0;
            if (we) model_write(cr, cc, wd);
            if (cmd) model_cmd(op, rr, cmd_fill);
            check("rnd_rd_data", rd_data, exp_rd);
            check("rnd_rvalid", cpu_rvalid, re);
            if (re) check("rnd_cpu_rdata", cpu_rdata, exp_cpu);
            if (cmd) begin
                check("rnd_cmd_top", top_row, m_top);
                wait_fill("rnd_cmd", (op == 2'b11) ? 0 : COLS, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
